// File: rtl/mem_dump_tx.sv
// mem_dump_tx
//   Reads an inclusive address range from the 21-bit external memory bus and
//   streams it over a UART as an 8N1 frame:
//   HDR_BYTE, the data bytes, then the checksum (mod-256 sum of the data bytes).
//   Runs from the UART clock while the Game Boy is held in reset. The memory
//   bus is only meaningful while busy is high.
//
// Ports
//   clk        UART/loader clock, all logic on the rising edge
//   n_reset    asynchronous active-low reset
//   start      dump request, only looked at in IDLE
//   start_adr  first address of the range (inclusive), captured on start
//   end_adr    last address of the range (inclusive), captured on start
//   adr        memory address, valid while read is high
//   read       memory read strobe, held for READ_WAIT+1 cycles per byte
//   data       memory read data, sampled on the last read cycle
//   n_cts      host ready (active low), double-flop synchronised here
//   tx         UART transmit line, idles high
//   busy       high from accepted start until the checksum stop bit ends
//   done       one-cycle pulse after the checksum stop bit
module mem_dump_tx #(
  parameter int         CLK_DIV   = 104,
  parameter int         READ_WAIT = 2,
  parameter logic [7:0] HDR_BYTE  = 8'hA5
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        start,
  input  logic [20:0] start_adr,
  input  logic [20:0] end_adr,
  output logic [20:0] adr,
  output logic        read,
  input  logic [7:0]  data,
  input  logic        n_cts,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int BW = $clog2(CLK_DIV);
  localparam int WW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'((READ_WAIT > 0) ? (READ_WAIT - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_FETCH, S_WAIT, S_SEND, S_CSUM, S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [20:0]   cur_adr_q, cur_adr_d;
  logic [20:0]   last_adr_q, last_adr_d;
  logic [20:0]   adr_q, adr_d;
  logic          read_q, read_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    csum_q, csum_d;
  logic [9:0]    frame_q, frame_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [BW-1:0] baud_cnt_q, baud_cnt_d;
  logic          sending_q, sending_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cts_meta_q, cts_meta_d;
  logic          cts_sync_q, cts_sync_d;

  logic [7:0]    tx_byte;
  logic          byte_last;

  always_comb begin
    state_d    = state_q;
    cur_adr_d  = cur_adr_q;
    last_adr_d = last_adr_q;
    adr_d      = adr_q;
    read_d     = read_q;
    data_d     = data_q;
    csum_d     = csum_q;
    frame_d    = frame_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    sending_d  = sending_q;
    wait_cnt_d = wait_cnt_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cts_meta_d = n_cts;
    cts_sync_d = cts_meta_q;

    tx_byte = csum_q;
    if (state_q == S_HDR) begin
      tx_byte = HDR_BYTE;
    end else if (state_q == S_SEND) begin
      tx_byte = data_q;
    end

    // Final cycle of the stop bit of the byte currently being shifted out.
    byte_last = sending_q && (bit_cnt_q == 4'd9) && (baud_cnt_q == BAUD_LAST);

    // Shared serialiser for header, data and checksum bytes. Flow control is
    // only consulted before the start bit, so a started byte always finishes.
    // The frame register holds {stop, data, start}; tx takes bit 1 at each
    // bit boundary as the register shifts in ones from the top.
    if (state_q inside {S_HDR, S_SEND, S_CSUM}) begin
      if (!sending_q) begin
        if (!cts_sync_q) begin
          sending_d  = 1'b1;
          frame_d    = {1'b1, tx_byte, 1'b0};
          tx_d       = 1'b0;
          bit_cnt_d  = 4'd0;
          baud_cnt_d = '0;
        end
      end else if (baud_cnt_q == BAUD_LAST) begin
        baud_cnt_d = '0;
        if (bit_cnt_q == 4'd9) begin
          sending_d = 1'b0;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          frame_d   = {1'b1, frame_q[9:1]};
          tx_d      = frame_q[1];
        end
      end else begin
        baud_cnt_d = baud_cnt_q + BW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_adr_d  = start_adr;
          last_adr_d = end_adr;
          csum_d     = 8'h00;
          busy_d     = 1'b1;
          sending_d  = 1'b0;
          state_d    = S_HDR;
        end
      end
      S_HDR: begin
        if (byte_last) begin
          if (last_adr_q < cur_adr_q) begin
            state_d = S_CSUM;
          end else begin
            adr_d   = cur_adr_q;
            read_d  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      // First read cycle; with no wait states the data is taken right here.
      S_FETCH: begin
        if (READ_WAIT == 0) begin
          data_d  = data;
          csum_d  = csum_q + data;
          read_d  = 1'b0;
          state_d = S_SEND;
        end else begin
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          data_d  = data;
          csum_d  = csum_q + data;
          read_d  = 1'b0;
          state_d = S_SEND;
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end
      // Equality termination means the address never wraps past 21'h1FFFFF.
      S_SEND: begin
        if (byte_last) begin
          if (cur_adr_q == last_adr_q) begin
            state_d = S_CSUM;
          end else begin
            cur_adr_d = cur_adr_q + 21'd1;
            adr_d     = cur_adr_q + 21'd1;
            read_d    = 1'b1;
            state_d   = S_FETCH;
          end
        end
      end
      S_CSUM: begin
        if (byte_last) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FIN;
        end
      end
      // Done is visible here; a start in this cycle is not looked at.
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset parks the line high and drops the bus immediately.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= S_IDLE;
      cur_adr_q  <= '0;
      last_adr_q <= '0;
      adr_q      <= '0;
      read_q     <= 1'b0;
      data_q     <= '0;
      csum_q     <= '0;
      frame_q    <= '1;
      bit_cnt_q  <= '0;
      baud_cnt_q <= '0;
      sending_q  <= 1'b0;
      wait_cnt_q <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cur_adr_q  <= cur_adr_d;
      last_adr_q <= last_adr_d;
      adr_q      <= adr_d;
      read_q     <= read_d;
      data_q     <= data_d;
      csum_q     <= csum_d;
      frame_q    <= frame_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      sending_q  <= sending_d;
      wait_cnt_q <= wait_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cts_meta_q <= cts_meta_d;
      cts_sync_q <= cts_sync_d;
    end
  end

  assign adr  = adr_q;
  assign read = read_q;
  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mem_dump_tx.sv
// tb_mem_dump_tx
//   Directed bench for mem_dump_tx with CLK_DIV=4 and READ_WAIT=2. A
//   behavioural UART receiver decodes tx into bytes, and monitors record read
//   strobes, addresses and done pulses, which are then compared against
//   hand-computed frames.
module tb_mem_dump_tx;

  localparam int CLK_DIV   = 4;
  localparam int READ_WAIT = 2;
  localparam int HALF      = CLK_DIV / 2;

  logic        clk = 1'b0;
  logic        n_reset = 1'b1;
  logic        start = 1'b0;
  logic [20:0] start_adr = '0;
  logic [20:0] end_adr = '0;
  logic [20:0] adr;
  logic        read;
  logic [7:0]  data;
  logic        n_cts = 1'b0;
  logic        tx;
  logic        busy;
  logic        done;

  logic        mem_ff = 1'b0;

  int errors = 0;
  int checks = 0;

  mem_dump_tx #(
    .CLK_DIV  (CLK_DIV),
    .READ_WAIT(READ_WAIT),
    .HDR_BYTE (8'hA5)
  ) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .start    (start),
    .start_adr(start_adr),
    .end_adr  (end_adr),
    .adr      (adr),
    .read     (read),
    .data     (data),
    .n_cts    (n_cts),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Memory returns the low address byte, or 0xFF everywhere when mem_ff is set.
  assign data = mem_ff ? 8'hFF : adr[7:0];

  // UART receiver: detect the start bit on a falling-edge sample, then sample
  // each bit near its middle.
  logic [7:0]  rx_q[$];
  int          low_run_q[$];
  logic [7:0]  rx_sh = '0;
  logic        rx_active = 1'b0;
  int          rx_tick = 0;
  int          rx_bit = 0;
  int          rx_frame_err = 0;
  int          low_run = 0;

  always @(negedge clk) begin
    if (!n_reset) begin
      rx_active = 1'b0;
      low_run   = 0;
    end else begin
      if (tx === 1'b0) begin
        low_run++;
      end else if (low_run > 0) begin
        low_run_q.push_back(low_run);
        low_run = 0;
      end
      if (!rx_active) begin
        if (tx === 1'b0) begin
          rx_active = 1'b1;
          rx_tick   = 0;
        end
      end else begin
        rx_tick++;
      end
      if (rx_active && (rx_tick % CLK_DIV == HALF)) begin
        rx_bit = rx_tick / CLK_DIV;
        if (rx_bit == 0) begin
          if (tx !== 1'b0) rx_active = 1'b0;
        end else if (rx_bit <= 8) begin
          rx_sh[rx_bit-1] = tx;
        end else begin
          if (tx !== 1'b1) rx_frame_err++;
          rx_q.push_back(rx_sh);
          rx_active = 1'b0;
        end
      end
    end
  end

  // Bus and handshake monitor.
  logic [20:0] rd_adr_q[$];
  int          rd_run_q[$];
  logic [20:0] rd_adr_last = '0;
  int          rd_run = 0;
  int          rd_total = 0;
  int          rd_unstable = 0;
  int          done_cnt = 0;
  logic        watch_zero = 1'b0;
  logic        zero_seen = 1'b0;

  always @(negedge clk) begin
    if (read === 1'b1) begin
      if (rd_run == 0) rd_adr_q.push_back(adr);
      else if (adr !== rd_adr_last) rd_unstable++;
      rd_adr_last = adr;
      rd_run++;
      rd_total++;
    end else if (rd_run > 0) begin
      rd_run_q.push_back(rd_run);
      rd_run = 0;
    end
    if (done === 1'b1) done_cnt++;
    if (watch_zero && adr === 21'd0) zero_seen = 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Cleared on a rising edge so it never races the falling-edge monitors.
  task automatic clearMonitors();
    @(posedge clk);
    rx_q.delete();
    low_run_q.delete();
    rd_adr_q.delete();
    rd_run_q.delete();
    rd_total     = 0;
    rd_unstable  = 0;
    done_cnt     = 0;
    rx_frame_err = 0;
  endtask

  task automatic applyStimulus(input logic [20:0] sa, input logic [20:0] ea);
    @(negedge clk);
    start_adr = sa;
    end_adr   = ea;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) checkOutput({tag, "_timeout"}, 0, 1);
    else checkOutput({tag, "_busy_at_done"}, busy, 0);
  endtask

  task automatic waitTxLow(input string tag, input int budget);
    int n = 0;
    while (tx !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) checkOutput({tag, "_tx_low_timeout"}, 0, 1);
  endtask

  // Byte i of the expected frame sits in bytes[8*i +: 8].
  task automatic checkFrame(input string tag, input int n, input logic [39:0] bytes);
    checkOutput({tag, "_nbytes"}, rx_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < rx_q.size())
        checkOutput($sformatf("%s_byte%0d", tag, i), {24'h0, rx_q[i]}, {24'h0, bytes[8*i +: 8]});
    end
    checkOutput({tag, "_stop_bits"}, rx_frame_err, 0);
  endtask

  task automatic checkAfterDone(input string tag);
    repeat (2) @(negedge clk);
    checkOutput({tag, "_done_pulses"}, done_cnt, 1);
    checkOutput({tag, "_busy_after"}, busy, 0);
    checkOutput({tag, "_done_after"}, done, 0);
    checkOutput({tag, "_read_after"}, read, 0);
  endtask

  task automatic checkReads123(input string tag);
    checkOutput({tag, "_nreads"}, rd_adr_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < rd_adr_q.size())
        checkOutput($sformatf("%s_rd_adr%0d", tag, i), rd_adr_q[i], 21'h10 + i);
      if (i < rd_run_q.size())
        checkOutput($sformatf("%s_rd_len%0d", tag, i), rd_run_q[i], READ_WAIT + 1);
    end
    checkOutput({tag, "_adr_stable"}, rd_unstable, 0);
  endtask

  initial begin
    int lat;
    int tx_low;

    // Reset state
    #3 n_reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_tx", tx, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_read", read, 0);
    checkOutput("rst_adr", adr, 0);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);

    // Test 1: basic three-byte dump
    $display("[TB] basic dump 0x10..0x12");
    clearMonitors();
    applyStimulus(21'h10, 21'h12);
    checkOutput("t1_busy_after_start", busy, 1);
    waitDone("t1", 2000);
    checkFrame("t1", 5, {8'h33, 8'h12, 8'h11, 8'h10, 8'hA5});
    checkReads123("t1");
    checkAfterDone("t1");

    // Test 2: empty range
    $display("[TB] empty range");
    clearMonitors();
    applyStimulus(21'h20, 21'h1F);
    waitDone("t2", 1000);
    checkFrame("t2", 2, {24'h0, 8'h00, 8'hA5});
    checkOutput("t2_no_reads", rd_total, 0);
    if (low_run_q.size() > 0) checkOutput("t2_zero_byte_low_cycles", low_run_q[$], 9 * CLK_DIV);
    else checkOutput("t2_zero_byte_low_seen", 0, 1);
    checkAfterDone("t2");

    // Test 3: flow control
    $display("[TB] n_cts flow control");
    clearMonitors();
    applyStimulus(21'h10, 21'h12);
    waitTxLow("t3", 200);
    n_cts = 1'b1;
    repeat (50) @(negedge clk);
    tx_low = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_low++;
    end
    checkOutput("t3_tx_idle_while_cts_high", tx_low, 0);
    checkOutput("t3_header_complete", rx_q.size(), 1);
    n_cts = 1'b0;
    lat = 0;
    while (tx !== 1'b0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("t3_resume_latency_2_to_3", (lat >= 2 && lat <= 3), 1);
    waitDone("t3", 2000);
    checkFrame("t3", 5, {8'h33, 8'h12, 8'h11, 8'h10, 8'hA5});
    checkAfterDone("t3");

    // Test 4: start while busy is ignored
    $display("[TB] start during busy");
    clearMonitors();
    applyStimulus(21'h10, 21'h12);
    repeat (60) @(negedge clk);
    applyStimulus(21'h50, 21'h60);
    waitDone("t4", 2000);
    checkFrame("t4", 5, {8'h33, 8'h12, 8'h11, 8'h10, 8'hA5});
    checkReads123("t4");
    checkAfterDone("t4");

    // Test 5: reset in the middle of the second byte, then a clean frame
    $display("[TB] reset mid-frame");
    clearMonitors();
    applyStimulus(21'h10, 21'h12);
    lat = 0;
    while (rx_q.size() < 1 && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    waitTxLow("t5", 200);
    repeat (10) @(negedge clk);
    n_reset = 1'b0;
    #1;
    checkOutput("t5_rst_tx", tx, 1);
    checkOutput("t5_rst_busy", busy, 0);
    checkOutput("t5_rst_read", read, 0);
    repeat (3) @(negedge clk);
    checkOutput("t5_rst_tx_held", tx, 1);
    n_reset = 1'b1;
    clearMonitors();
    applyStimulus(21'h10, 21'h12);
    waitDone("t5", 2000);
    checkFrame("t5", 5, {8'h33, 8'h12, 8'h11, 8'h10, 8'hA5});
    checkAfterDone("t5");

    // Test 6: single byte at the top of the address space
    $display("[TB] top address");
    clearMonitors();
    mem_ff     = 1'b1;
    watch_zero = 1'b1;
    zero_seen  = 1'b0;
    applyStimulus(21'h1FFFFF, 21'h1FFFFF);
    waitDone("t6", 2000);
    checkFrame("t6", 3, {16'h0, 8'hFF, 8'hFF, 8'hA5});
    checkOutput("t6_nreads", rd_adr_q.size(), 1);
    if (rd_adr_q.size() > 0) checkOutput("t6_rd_adr", rd_adr_q[0], 21'h1FFFFF);
    if (rd_run_q.size() > 0) checkOutput("t6_rd_len", rd_run_q[0], READ_WAIT + 1);
    checkAfterDone("t6");
    checkOutput("t6_adr_never_zero", zero_seen, 0);
    watch_zero = 1'b0;
    mem_ff     = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
